// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/exec/writeback sequencer for the register file instruction side
// Optional fetch stall watchdog: define SEQ_STALL_TIMEOUT_EN.
module instr_sequencer #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic [15:0] rd_data_a,
    output logic [31:0] instr,
    output logic        writing_to_reg,
    output logic        halted,
    output logic        bad_reg,
    output logic        fault,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_WB     = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [2:0] OP_ALU   = 3'b001;
    localparam logic [2:0] OP_LOADI = 3'b010;
    localparam logic [2:0] OP_JUMP  = 3'b011;
    localparam logic [2:0] OP_BEQZ  = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        bad_q, bad_d;
    logic [15:0] count_q, count_d;
    logic        fault_q, fault_d;

`ifdef SEQ_STALL_TIMEOUT_EN
    logic [31:0] wait_q, wait_d;
`else
    logic        unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    logic [2:0]  opcode;
    logic [15:0] pc_inc;
    assign opcode = instr_q[31:29];
    assign pc_inc = pc_q + 16'd1;

    // Reset lands the FSM in FETCH, so the request is masked while reset is held.
    assign imem_req       = (state_q == S_FETCH) && !reset;
    assign imem_addr      = pc_q;
    assign instr          = instr_q;
    assign writing_to_reg = (state_q == S_WB) && !instr_q[28];
    assign halted         = (state_q == S_HALTED);
    assign bad_reg        = bad_q;
    assign fault          = fault_q;
    assign instr_count    = count_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        bad_d   = bad_q;
        count_d = count_q;
        fault_d = fault_q;
`ifdef SEQ_STALL_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_data;
                    state_d = S_EXEC;
`ifdef SEQ_STALL_TIMEOUT_EN
                    wait_d  = 32'd0;
                end else if (wait_q == 32'(TIMEOUT_CYCLES)) begin
                    fault_d = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    wait_d  = wait_q + 32'd1;
`endif
                end
            end
            S_EXEC: begin
                count_d = count_q + 16'd1;
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_HALT: begin
                        state_d = S_HALTED;
                        pc_d    = pc_q;
                    end
                    OP_ALU, OP_LOADI: state_d = S_WB;
                    OP_JUMP:          pc_d = instr_q[15:0];
                    OP_BEQZ:          pc_d = (rd_data_a == 16'd0) ? instr_q[15:0] : pc_inc;
                    default:          ;
                endcase
            end
            S_WB: begin
                if (instr_q[28]) bad_d = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_HALTED;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            bad_q   <= 1'b0;
            count_q <= 16'd0;
            fault_q <= 1'b0;
`ifdef SEQ_STALL_TIMEOUT_EN
            wait_q  <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            bad_q   <= bad_d;
            count_q <= count_d;
            fault_q <= fault_d;
`ifdef SEQ_STALL_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - vector table, corner sequences and random program run for instr_sequencer
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data;
    logic [15:0] rd_data_a = 16'd0;
    logic [31:0] instr;
    logic        writing_to_reg;
    logic        halted;
    logic        bad_reg;
    logic        fault;
    logic [15:0] instr_count;

    logic [31:0] mem [0:65535];
    assign imem_data = mem[imem_addr];

    instr_sequencer dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data),
        .rd_data_a(rd_data_a), .instr(instr),
        .writing_to_reg(writing_to_reg), .halted(halted),
        .bad_reg(bad_reg), .fault(fault), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int wr_cycles = 0;
    logic [15:0] exp_pc;
    logic [15:0] exp_count;
    logic        exp_bad;
    logic        exp_halt;

    always @(negedge clock) wr_cycles += int'(writing_to_reg);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        imem_ready = 1'b0;
        rd_data_a  = 16'd0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_wr", writing_to_reg, 0);
        chk("rst_halted", halted, 0);
        chk("rst_bad", bad_reg, 0);
        chk("rst_fault", fault, 0);
        chk("rst_count", instr_count, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("req_after_reset", imem_req, 1);
        exp_pc = 16'd0; exp_count = 16'd0; exp_bad = 1'b0; exp_halt = 1'b0;
        wr_cycles = 0;
    endtask

    // Spec-level timing: FETCH (+stalls), EXEC, optional WB; entered with the DUT in FETCH.
    task automatic step_instr(input int stall_max, input logic rnd_rd, input logic [15:0] rd_val);
        logic [31:0] w;
        logic [2:0]  op;
        logic [15:0] rd;
        int stalls;
        stalls = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
        for (int i = 0; i <= stalls; i++) begin
            chk("fetch_req", imem_req, 1);
            chk("fetch_addr", imem_addr, exp_pc);
            imem_ready = (i == stalls);
            @(posedge clock); @(negedge clock);
        end
        w  = mem[exp_pc];
        op = w[31:29];
        chk("exec_instr", instr, w);
        chk("exec_req", imem_req, 0);
        chk("exec_wr", writing_to_reg, 0);
        imem_ready = 1'($urandom_range(1, 0));
        if (rnd_rd) rd = ($urandom_range(1, 0) == 1) ? 16'd0 : 16'($urandom);
        else        rd = rd_val;
        rd_data_a = rd;
        @(posedge clock); @(negedge clock);
        exp_count = exp_count + 16'd1;
        case (op)
            3'b111: exp_halt = 1'b1;
            3'b001, 3'b010: begin
                chk("wb_wr", writing_to_reg, {31'd0, ~w[28]});
                chk("wb_instr", instr, w);
                exp_bad = exp_bad | w[28];
                exp_pc  = exp_pc + 16'd1;
                @(posedge clock); @(negedge clock);
            end
            3'b011: exp_pc = w[15:0];
            3'b100: exp_pc = (rd == 16'd0) ? w[15:0] : exp_pc + 16'd1;
            default: exp_pc = exp_pc + 16'd1;
        endcase
        chk("count", instr_count, exp_count);
        chk("bad_reg", bad_reg, exp_bad);
        chk("halted", halted, exp_halt);
        chk("req_next", imem_req, !exp_halt);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [15:0] rd;
        logic [15:0] next_addr;
        int          wr;
        logic        bad;
        logic        halt;
    } vec_t;

    vec_t vecs [8];

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'd0;

        vecs[0] = '{32'h42000005, 16'd0, 16'h0001, 1, 1'b0, 1'b0};
        vecs[1] = '{32'h60000010, 16'd0, 16'h0010, 0, 1'b0, 1'b0};
        vecs[2] = '{32'h80000020, 16'd0, 16'h0020, 0, 1'b0, 1'b0};
        vecs[3] = '{32'h80000020, 16'd5, 16'h0001, 0, 1'b0, 1'b0};
        vecs[4] = '{32'h32000000, 16'd0, 16'h0001, 0, 1'b1, 1'b0};
        vecs[5] = '{32'hE0000000, 16'd0, 16'h0000, 0, 1'b0, 1'b1};
        vecs[6] = '{32'h20000000, 16'd0, 16'h0001, 1, 1'b0, 1'b0};
        vecs[7] = '{32'hA0000000, 16'd0, 16'h0001, 0, 1'b0, 1'b0};

        for (int v = 0; v < 8; v++) begin
            mem[0] = vecs[v].word;
            do_reset();
            step_instr(0, 1'b0, vecs[v].rd);
            chk("vec_next_addr", imem_addr, vecs[v].next_addr);
            chk("vec_wr_cycles", wr_cycles, vecs[v].wr);
            chk("vec_bad", bad_reg, vecs[v].bad);
            chk("vec_halt", halted, vecs[v].halt);
            chk("vec_count", instr_count, 1);
            for (int c = 0; c < 20; c++) begin
                @(posedge clock); @(negedge clock);
            end
            chk("vec_bad_sticky", bad_reg, vecs[v].bad);
            chk("vec_halt_hold", halted, vecs[v].halt);
            if (vecs[v].halt) chk("vec_halt_req", imem_req, 0);
        end
        mem[0] = 32'd0;

        // Reset asserted in the middle of a WB cycle cuts the strobe at once.
        mem[0] = 32'h42000005;
        do_reset();
        imem_ready = 1'b1;
        @(posedge clock); @(posedge clock); @(negedge clock);
        chk("midwb_wr", writing_to_reg, 1);
        #1 reset = 1'b1;
        #1;
        chk("midwb_cut", writing_to_reg, 0);
        chk("midwb_req", imem_req, 0);
        chk("midwb_instr", instr, 0);
        chk("midwb_count", instr_count, 0);

        // PC increment wraps from 0xFFFF to 0x0000.
        mem[0]     = 32'h6000FFFF;
        mem[16'hFFFF] = 32'h00000000;
        do_reset();
        step_instr(0, 1'b0, 16'd0);
        step_instr(2, 1'b0, 16'd0);
        chk("pc_wrap", imem_addr, 16'h0000);
        mem[0] = 32'd0;
        mem[16'hFFFF] = 32'd0;

`ifdef SEQ_STALL_TIMEOUT_EN
        do_reset();
        for (int c = 0; c < 255; c++) begin
            @(posedge clock); @(negedge clock);
        end
        chk("to_not_yet", fault, 0);
        chk("to_not_yet_addr", imem_addr, 0);
        @(posedge clock); @(negedge clock);
        chk("to_fault", fault, 1);
        chk("to_halted", halted, 1);
        chk("to_req", imem_req, 0);

        mem[0] = 32'h60000033;
        do_reset();
        for (int c = 0; c < 255; c++) begin
            @(posedge clock); @(negedge clock);
        end
        imem_ready = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("to_race_fault", fault, 0);
        chk("to_race_instr", instr, 32'h60000033);
        chk("to_race_halted", halted, 0);
        mem[0] = 32'd0;
`else
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            @(posedge clock); @(negedge clock);
            if (imem_req !== 1'b1 || imem_addr !== 16'd0 || fault !== 1'b0 || c == 999) begin
                chk("stall_req", imem_req, 1);
                chk("stall_addr", imem_addr, 0);
                chk("stall_fault", fault, 0);
                break;
            end
        end
`endif

        // Random program: no HALT, targets kept in low memory.
        for (int a = 0; a < 512; a++) begin
            logic [2:0] op;
            logic [31:0] w;
            op = 3'($urandom_range(6, 0));
            w  = $urandom;
            w[31:29] = op;
            w[15:0]  = {8'd0, w[7:0]};
            mem[a] = w;
        end
        do_reset();
        for (int n = 0; n < 300; n++) step_instr(3, 1'b1, 16'd0);
        chk("rand_count", instr_count, 16'd300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Drives the register file's instruction-side interface: `instr`, `writing_to_reg`, and reads back `rd_data_a`.
- Fetches 32-bit instruction words from instruction memory through a req/ready handshake.
- Holds each word stable while the datapath executes it, and issues a single-cycle register write strobe for writing opcodes.
- Owns the PC, jump/branch-on-zero control, halt, and a retired-instruction counter.

## Interface
- `RESET_PC`, default `16'h0000`: PC value loaded on reset.
- `TIMEOUT_CYCLES`, default `255`: maximum cycles `imem_req` may wait for `imem_ready`; only used when `SEQ_STALL_TIMEOUT_EN` is defined.
- `clock`: input, 1 bit. Clock.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `imem_req`: output, 1 bit. Fetch request.
- `imem_addr`: output, 16 bits. Word address, equal to the PC.
- `imem_ready`: input, 1 bit. Memory has `imem_data` valid for the current `imem_addr`.
- `imem_data`: input, 32 bits. Fetched instruction.
- `rd_data_a`: input, 16 bits. Register file port A, indexed by `instr[24:21]`.
- `instr`: output, 32 bits. Latched instruction to the register file and datapath.
- `writing_to_reg`: output, 1 bit. Register write strobe.
- `halted`: output, 1 bit. Sequencer stopped.
- `bad_reg`: output, 1 bit. Sticky flag: a write targeted an index of 8 or more.
- `fault`: output, 1 bit. Sticky flag: fetch timeout.
- `instr_count`: output, 16 bits. Retired-instruction count; wraps.

## Operation
- **Instruction fields:**
  - opcode `instr[31:29]`
  - dest `instr[28:25]`
  - src a `instr[24:21]`
  - src b `instr[20:17]`
  - immediate `instr[15:0]`
- **Opcodes:**
  - `000` NOP.
  - `001` ALU: writes dest.
  - `010` LOADI: writes dest; the datapath selects the immediate as `wr_data`.
  - `011` JUMP: PC ← immediate.
  - `100` BEQZ: PC ← immediate if `rd_data_a == 0`, else PC+1.
  - `111` HALT.
  - `101` and `110` execute as NOP.
- **States:**
  - FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_ready`=1, latch `imem_data` into `instr`, go to EXEC. Otherwise stay with `imem_addr` held stable.
  - EXEC: decode.
    - HALT → HALTED.
    - ALU/LOADI → WB.
    - All others → FETCH.
    - PC is updated here for every non-HALT opcode: JUMP/BEQZ target, else PC+1.
    - BEQZ samples `rd_data_a` in this cycle.
  - WB: `writing_to_reg`=1 for exactly one cycle, then go to FETCH.
  - HALTED: `halted`=1, `imem_req`=0. Exits only via reset.
- **Invalid dest:** if dest[3]=1, WB still occupies its cycle but `writing_to_reg` stays 0 and `bad_reg` sets. `bad_reg` clears only on reset.
- **`instr` stability:** `instr` is stable from the EXEC cycle through the end of WB.
- **PC arithmetic:** 16-bit, unsigned; PC+1 wraps `0xFFFF` → `0x0000`.
- **`instr_count`:** increments by 1 on leaving EXEC (HALT included); 16-bit, wraps.

## Timing
- **Reset values:**
  - state FETCH, PC=`RESET_PC`
  - `instr`=0, `writing_to_reg`=0, `imem_req`=0
  - `halted`=0, `bad_reg`=0, `fault`=0, `instr_count`=0
- **After reset:** `imem_req` rises in the first cycle after `reset` deasserts.
- **Throughput, with `imem_ready` high in the first FETCH cycle:**
  - NOP/JUMP/BEQZ: 2 cycles each.
  - ALU/LOADI: 3 cycles each.
  - Each cycle of `imem_ready`=0 adds one cycle.
- **Handshake:** `imem_req` and `imem_addr` are held until the edge on which `imem_ready`=1. `imem_req` drops in EXEC.
- **Reset mid-operation:** takes effect immediately. A pending fetch is abandoned and any WB strobe is cut.

## Configuration
- **`SEQ_STALL_TIMEOUT_EN` defined:**
  - A wait counter runs while FETCH waits on `imem_ready`.
  - The counter clears on each accepted fetch.
  - After `TIMEOUT_CYCLES`+1 consecutive cycles of `imem_ready`=0: set `fault`=1 and go to HALTED.
  - `imem_ready` arriving on the same edge as the timeout wins, and the fetch is accepted.
- **Undefined:** no counter; FETCH waits indefinitely and `fault` is tied 0.

## Test plan
1. Reset, then mem[0]=`0x42000005` with ready always high → `imem_addr`=0. `writing_to_reg`=1 for exactly one cycle, in cycle 3, with `instr`=`0x42000005`. Next `imem_addr`=1, `instr_count`=1.
2. mem[0]=`0x60000010` → next `imem_addr`=`0x0010`; `writing_to_reg` never rises.
3. mem[0]=`0x80000020`:
   - with `rd_data_a`=0 → next `imem_addr`=`0x0020`;
   - rerun with `rd_data_a`=5 → next `imem_addr`=`0x0001`.
4. mem[0]=`0x32000000` (ALU, dest 9) → WB cycle occurs with `writing_to_reg`=0; `bad_reg`=1 and stays 1 until reset.
5. mem[0]=`0xE0000000` → `halted`=1 and `imem_req`=0 indefinitely; `instr_count`=1; asserting reset returns all outputs to reset values.
6. Hold `imem_ready`=0:
   - with `SEQ_STALL_TIMEOUT_EN` → `fault`=1 and `halted`=1 after 256 cycles;
   - without it → `imem_req`=1 with `imem_addr` stable for 1000 cycles and `fault`=0.
